// File: rtl/cam9t_array.sv
// cam9t_array: register-level model of a 9T CAM macro.
// Each entry holds WIDTH bits of Q and a valid flag. The array provides a
// differential write port, a single-ended precharged read port, and a
// registered search that returns a per-entry mismatch line together with
// the lowest matching index.
//
// Valid-signal semantics: there is no ready or back-pressure. rd_valid is high
// for exactly one cycle after each clock edge that sampled rwl=1, and
// srch_valid is high for exactly one cycle after each edge that sampled
// srch=1. Each one qualifies the result registers it accompanies.
module cam9t_array #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wlwr,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] dl,
    input  logic [WIDTH-1:0] dlb,
    input  logic             rwl,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rbl,
    output logic             rd_valid,
    input  logic             srch,
    input  logic [WIDTH-1:0] cam_data,
    output logic [DEPTH-1:0] mismatch,
    output logic             hit,
    output logic [AW-1:0]    hit_idx,
    output logic             srch_valid
);

    logic [WIDTH-1:0] q_mem [DEPTH];
    logic [DEPTH-1:0] entry_valid;
    logic [DEPTH-1:0] line_mm;
    logic             hit_c;
    logic [AW-1:0]    idx_c;
    logic [WIDTH-1:0] drive;

    // A bit is driven only when dl and dlb disagree. Otherwise the cell keeps its value.
    assign drive = dl ^ dlb;

    // Match lines: the cell mismatch is Q XOR key, and an empty entry never matches.
    always_comb begin
        line_mm = '0;
        for (int e = 0; e < DEPTH; e++) begin
            line_mm[e] = ~entry_valid[e] | (|(q_mem[e] ^ cam_data));
        end
    end

    // Priority encoder: pick the lowest matching entry, or 0 when nothing matches.
    always_comb begin
        idx_c = '0;
        hit_c = ~(&line_mm);
        for (int e = DEPTH - 1; e >= 0; e--) begin
            if (!line_mm[e]) begin
                idx_c = e[AW-1:0];
            end
        end
    end

    // Storage array and valid bits. Reads and searches elsewhere see the pre-write contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < DEPTH; e++) begin
                q_mem[e] <= '0;
            end
            entry_valid <= '0;
        end else if (wlwr) begin
            q_mem[wr_addr]       <= (q_mem[wr_addr] & ~drive) | (dl & drive);
            entry_valid[wr_addr] <= 1'b1;
        end
    end

    // Read port: the bit line discharges where Q=0 and stays precharged when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rbl      <= '1;
            rd_valid <= 1'b0;
        end else if (rwl) begin
            rbl      <= q_mem[rd_addr];
            rd_valid <= 1'b1;
        end else begin
            rbl      <= '1;
            rd_valid <= 1'b0;
        end
    end

    // Search result registers. They hold their last values when no search is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch   <= '1;
            hit        <= 1'b0;
            hit_idx    <= '0;
            srch_valid <= 1'b0;
        end else begin
            srch_valid <= srch;
            if (srch) begin
                mismatch <= line_mm;
                hit      <= hit_c;
                hit_idx  <= idx_c;
            end
        end
    end

endmodule

// File: tb/tb_cam9t_array.sv
// tb_cam9t_array: scoreboard bench for cam9t_array. A behavioural model
// predicts the search and read results at drive time. The predictions go into
// queues and are compared when the DUT reports them.
module tb_cam9t_array;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int SW    = DEPTH + 1 + AW;

    logic             clk;
    logic             rst;
    logic             wlwr;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] dl;
    logic [WIDTH-1:0] dlb;
    logic             rwl;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rbl;
    logic             rd_valid;
    logic             srch;
    logic [WIDTH-1:0] cam_data;
    logic [DEPTH-1:0] mismatch;
    logic             hit;
    logic [AW-1:0]    hit_idx;
    logic             srch_valid;

    cam9t_array #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .wlwr(wlwr), .wr_addr(wr_addr), .dl(dl), .dlb(dlb),
        .rwl(rwl), .rd_addr(rd_addr), .rbl(rbl), .rd_valid(rd_valid),
        .srch(srch), .cam_data(cam_data), .mismatch(mismatch),
        .hit(hit), .hit_idx(hit_idx), .srch_valid(srch_valid)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // model state and scoreboards
    logic [WIDTH-1:0] mdl_q [DEPTH];
    logic             mdl_v [DEPTH];
    logic [SW-1:0]    exp_q [$];
    logic [WIDTH-1:0] rd_q  [$];
    logic [SW-1:0]    last_srch;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int e = 0; e < DEPTH; e++) begin
            mdl_q[e] = '0;
            mdl_v[e] = 1'b0;
        end
        last_srch = {{DEPTH{1'b1}}, 1'b0, {AW{1'b0}}};
    endtask

    function automatic logic [SW-1:0] model_search(input logic [WIDTH-1:0] key);
        logic [DEPTH-1:0] mm;
        logic             h;
        logic [AW-1:0]    idx;
        mm  = '0;
        h   = 1'b0;
        idx = '0;
        for (int e = 0; e < DEPTH; e++) begin
            if (mdl_v[e] && mdl_q[e] == key) begin
                if (!h) idx = AW'(e);
                h = 1'b1;
            end else begin
                mm[e] = 1'b1;
            end
        end
        return {mm, h, idx};
    endfunction

    // driver: one clock cycle of combined write/read/search, then compare the results
    task automatic drive_cycle(input logic w, input logic [AW-1:0] wa, input logic [WIDTH-1:0] d,
                               input logic [WIDTH-1:0] db, input logic r, input logic [AW-1:0] ra,
                               input logic s, input logic [WIDTH-1:0] key);
        logic [SW-1:0]    es;
        logic [WIDTH-1:0] er;
        wlwr = w; wr_addr = wa; dl = d; dlb = db;
        rwl = r; rd_addr = ra; srch = s; cam_data = key;
        if (s) exp_q.push_back(model_search(key));
        if (r) rd_q.push_back(mdl_q[ra]);
        if (w) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (d[i] && !db[i]) mdl_q[wa][i] = 1'b1;
                else if (!d[i] && db[i]) mdl_q[wa][i] = 1'b0;
            end
            mdl_v[wa] = 1'b1;
        end
        @(posedge clk);
        #1;
        check_eq("srch_valid", 32'(srch_valid), 32'(s));
        check_eq("rd_valid", 32'(rd_valid), 32'(r));
        if (r && rd_q.size() > 0) begin
            er = rd_q.pop_front();
            check_eq("rbl_read", 32'(rbl), 32'(er));
        end else begin
            check_eq("rbl_idle", 32'(rbl), 32'hFF);
        end
        if (s && exp_q.size() > 0) begin
            es = exp_q.pop_front();
            last_srch = es;
        end
        check_eq("mismatch", 32'(mismatch), 32'(last_srch[SW-1 -: DEPTH]));
        check_eq("hit", 32'(hit), 32'(last_srch[AW]));
        check_eq("hit_idx", 32'(hit_idx), 32'(last_srch[AW-1:0]));
    endtask

    task automatic write_op(input logic [AW-1:0] wa, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] db);
        drive_cycle(1'b1, wa, d, db, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic search_op(input logic [WIDTH-1:0] key);
        drive_cycle(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, key);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rbl"}, 32'(rbl), 32'hFF);
        check_eq({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        check_eq({tag, "_mismatch"}, 32'(mismatch), 32'hFFFF);
        check_eq({tag, "_hit"}, 32'(hit), 32'd0);
        check_eq({tag, "_hit_idx"}, 32'(hit_idx), 32'd0);
        check_eq({tag, "_srch_valid"}, 32'(srch_valid), 32'd0);
    endtask

    initial begin
        wlwr = 0; wr_addr = '0; dl = '0; dlb = '0;
        rwl = 0; rd_addr = '0; srch = 0; cam_data = '0;
        model_clear();
        rst = 1'b1;
        #2;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // empty array: nothing can match
        search_op(8'h00);
        // single entry, exact key and one-bit-off key
        write_op(4'd3, 8'hA5, 8'h5A);
        search_op(8'hA5);
        search_op(8'hA4);
        // duplicates: the lowest index wins
        write_op(4'd5, 8'h3C, 8'hC3);
        write_op(4'd2, 8'h3C, 8'hC3);
        search_op(8'h3C);
        // equal dl/dlb leaves the entry untouched, then read it and idle
        write_op(4'd3, 8'hFF, 8'hFF);
        drive_cycle(1'b0, '0, '0, '0, 1'b1, 4'd3, 1'b0, '0);
        drive_cycle(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0);
        search_op(8'hA5);
        // search in the same cycle as a write sees the old contents
        drive_cycle(1'b1, 4'd1, 8'h11, 8'hEE, 1'b0, '0, 1'b1, 8'h11);
        search_op(8'h11);
        // read in the same cycle as a write to that address returns the old data
        drive_cycle(1'b1, 4'd2, 8'h77, 8'h88, 1'b1, 4'd2, 1'b0, '0);
        drive_cycle(1'b0, '0, '0, '0, 1'b1, 4'd2, 1'b0, '0);

        // random mix of concurrent operations
        for (int n = 0; n < 40; n++) begin
            logic [WIDTH-1:0] key;
            key = ($urandom_range(0, 1) == 1) ? mdl_q[$urandom_range(0, DEPTH - 1)]
                                              : WIDTH'($urandom_range(0, 255));
            drive_cycle(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
                        WIDTH'($urandom_range(0, 255)), WIDTH'($urandom_range(0, 255)),
                        1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
                        1'($urandom_range(0, 1)), key);
        end

        // leave hit/read outputs active, then reset asynchronously between edges
        write_op(4'd6, 8'h5E, 8'hA1);
        drive_cycle(1'b0, '0, '0, '0, 1'b1, 4'd6, 1'b1, 8'h5E);
        wlwr = 0; rwl = 0; srch = 0;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        model_clear();
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        search_op(8'h5E);
        search_op(8'h11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cam9t_array.md
Name: cam9t_array

Overview:
- Clocked, synthesizable CAM macro model built from 9T CAM bit cells.
- Each cell stores one bit Q, written differentially through a write port.
- Each cell has a decoupled single-ended read port, and drives a mismatch output equal to key XOR Q.
- Sits between the mobile SoC lookup controller and the match/priority logic, and returns registered hit, index and read data.

Parameters:
- WIDTH, 8, bits per entry (search key / data width).
- DEPTH, 16, number of entries; power of two, at least 2.
- AW, log2(DEPTH), address width (derived, not overridable).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- wlwr  in  1  write word-line enable.
- wr_addr  in  AW  entry selected for write.
- dl  in  WIDTH  write data line (true).
- dlb  in  WIDTH  write data line (complement).
- rwl  in  1  read word-line enable.
- rd_addr  in  AW  entry selected for read.
- rbl  out  WIDTH  read bit line, precharge-high model: bit is 0 when the stored Q is 0.
- rd_valid  out  1  rbl holds fresh read data.
- srch  in  1  search strobe.
- cam_data  in  WIDTH  search key.
- mismatch  out  DEPTH  per-entry match line, active-high mismatch.
- hit  out  1  at least one entry matched.
- hit_idx  out  AW  lowest-index matching entry.
- srch_valid  out  1  search results valid.

Behaviour:
- Storage: DEPTH x WIDTH register array Q, plus a per-entry valid bit.
- Reset (async, rst=1):
  - all Q = 0 and all valid bits = 0.
  - rbl = all 1s (precharged); rd_valid = 0.
  - mismatch = all 1s; hit = 0; hit_idx = 0; srch_valid = 0.
- Write (clock edge with wlwr=1), per bit i:
  - dl[i]=1, dlb[i]=0: Q[wr_addr][i] <= 1.
  - dl[i]=0, dlb[i]=1: Q[wr_addr][i] <= 0.
  - dl[i]==dlb[i]: bit holds its value (no differential drive).
  - The entry's valid bit is set on any write.
- Read (clock edge with rwl=1):
  - rbl <= Q[rd_addr], i.e. the line is discharged where Q=0.
  - rd_valid <= 1.
- Idle read (rwl=0 at clock edge): rbl <= all 1s; rd_valid <= 0.
- Cell mismatch: Q[e][i] XOR cam_data[i]. This follows the transmission-gate structure: Q=1 passes ~key, Q=0 passes key.
- Entry line: mismatch[e] = OR over i of the cell mismatches, forced 1 if entry e is not valid.
- Search (clock edge with srch=1):
  - mismatch, hit and hit_idx are registered.
  - hit = ~AND(mismatch).
  - hit_idx = lowest e with mismatch[e]=0.
  - srch_valid <= 1.
- Search latency: 1 cycle.
- Idle search (srch=0): srch_valid <= 0; mismatch, hit and hit_idx hold their last values.
- No hit: hit=0 and hit_idx=0.
- Search and write to the same entry in the same cycle: the search compares the pre-write contents (read-before-write). The write is visible from the next cycle.
- Read and write to the same address in the same cycle: rbl returns the old data.
- Simultaneous write, read and search are all legal; no back-pressure.
- rst asserted mid-operation clears everything immediately, with no wait for a clock edge.
- Out-of-range addresses cannot occur, since DEPTH is a power of two.

Test Plan:
- Reset then search key 0x00 -> mismatch=0xFFFF, hit=0, hit_idx=0, srch_valid=1 one cycle after srch.
- Write entry 3 with dl=0xA5, dlb=0x5A; then search 0xA5 -> hit=1, hit_idx=3, mismatch[3]=0. Search 0xA4 -> hit=0.
- Write entry 5 = 0x3C and entry 2 = 0x3C; search 0x3C -> hit_idx=2 and mismatch has bits 2 and 5 clear.
- Entry 3 = 0xA5; write entry 3 with dl=0xFF, dlb=0xFF (all bits equal) -> entry stays 0xA5. Read entry 3 -> rbl=0xA5, rd_valid=1. Next idle cycle -> rbl=0xFF, rd_valid=0.
- Same cycle: write entry 1 = 0x11 and search 0x11 (entry 1 previously empty) -> hit=0. Repeat the search next cycle -> hit=1, hit_idx=1.
- Assert rst asynchronously between edges after several writes -> all outputs return to reset values immediately. A following search of the old data -> hit=0.
